// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: stalls and flushes the 5-stage pipe for data-memory waits, taken branches and load-use.
// Latency: stall/flush outputs are combinational from the current inputs; FSM, timeout and counters update on clk_i.
// Backpressure: a pending data access (dmem_req_i && !dmem_ready_i) freezes every stage and overrides branch and load-use.
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   rs1/rs2_id_i, rs*_used_i  source registers of the IF_ID instruction and whether they are read
//   rd_ex_i, mem_read_ex_i    destination register of the ID_EX instruction and whether it is a load
//   branch_taken_ex_i         taken branch/jump resolved in EX
//   dmem_req_i, dmem_ready_i  MEM-stage data access request and completion
//   stall_*_o, flush_*_o      hold PC/IF_ID/ID_EX/EX_MEM, clear IF_ID/ID_EX to a bubble
//   hazard_state_o            0 = RUN, 1 = MEM_WAIT
//   mem_timeout_o             sticky: a memory wait lasted TIMEOUT_CYC cycles
//   lu_stall_cnt_o, mem_stall_cnt_o  performance counters (built only with HAZARD_PERF_CNT_EN defined)
module hazard_stall_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [4:0]  rs1_id_i,
    input  logic [4:0]  rs2_id_i,
    input  logic        rs1_used_i,
    input  logic        rs2_used_i,
    input  logic [4:0]  rd_ex_i,
    input  logic        mem_read_ex_i,
    input  logic        branch_taken_ex_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ready_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_ex_o,
    output logic        stall_mem_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic [1:0]  hazard_state_o,
    output logic        mem_timeout_o,
    output logic [15:0] lu_stall_cnt_o,
    output logic [15:0] mem_stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1
    } state_e;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;

    logic mem_wait;
    logic load_use;
    logic lu_stall;

    assign mem_wait = dmem_req_i && !dmem_ready_i;
    assign load_use = mem_read_ex_i && (rd_ex_i != 5'd0) &&
                      ((rs1_used_i && (rd_ex_i == rs1_id_i)) ||
                       (rs2_used_i && (rd_ex_i == rs2_id_i)));
    // A load-use stall only happens when neither a freeze nor a branch outranks it.
    assign lu_stall = load_use && !mem_wait && !branch_taken_ex_i;

    // Stall/flush decode. Gated by reset so the pipe sees no control activity while held in reset.
    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        stall_mem_o = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        if (rst_n_i) begin
            if (mem_wait) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                stall_ex_o  = 1'b1;
                stall_mem_o = 1'b1;
            end else if (branch_taken_ex_i) begin
                // A branch held in EX through a freeze lands here on the first unfrozen cycle.
                flush_id_o = 1'b1;
                flush_ex_o = 1'b1;
            end else if (load_use) begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
                flush_ex_o = 1'b1;
            end
        end
    end

    // Next-state logic for the wait FSM, wait counter and sticky timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = 16'd0;
                if (mem_wait) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (wait_cnt_q != 16'hFFFF) wait_cnt_d = wait_cnt_q + 16'd1;
                if (wait_cnt_q == TIMEOUT_LAST) timeout_d = 1'b1;
                if (dmem_ready_i || !dmem_req_i) state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hazard_state_o = state_q;
    assign mem_timeout_o  = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] lu_cnt_q, lu_cnt_d;
    logic [15:0] mem_cnt_q, mem_cnt_d;

    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        mem_cnt_d = mem_cnt_q;
        if (lu_stall && (lu_cnt_q != 16'hFFFF))  lu_cnt_d  = lu_cnt_q + 16'd1;
        if (mem_wait && (mem_cnt_q != 16'hFFFF)) mem_cnt_d = mem_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lu_cnt_q  <= 16'd0;
            mem_cnt_q <= 16'd0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end

    assign lu_stall_cnt_o  = lu_cnt_q;
    assign mem_stall_cnt_o = mem_cnt_q;
`else
    logic unused_lu_stall;
    assign unused_lu_stall = lu_stall;
    assign lu_stall_cnt_o  = 16'd0;
    assign mem_stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed scenarios followed by randomized traffic.
// Each cycle's outputs are compared against a cycle-level reference model of the hazard rules.
// Runs with TIMEOUT_CYC = 4 so timeouts occur within short waits.
module tb_hazard_stall_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        rs1_used, rs2_used, mem_read_ex, branch_taken_ex, dmem_req, dmem_ready;
    logic        stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
    logic [1:0]  hazard_state;
    logic        mem_timeout;
    logic [15:0] lu_stall_cnt, mem_stall_cnt;

    hazard_stall_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .rs1_id_i         (rs1_id),
        .rs2_id_i         (rs2_id),
        .rs1_used_i       (rs1_used),
        .rs2_used_i       (rs2_used),
        .rd_ex_i          (rd_ex),
        .mem_read_ex_i    (mem_read_ex),
        .branch_taken_ex_i(branch_taken_ex),
        .dmem_req_i       (dmem_req),
        .dmem_ready_i     (dmem_ready),
        .stall_if_o       (stall_if),
        .stall_id_o       (stall_id),
        .stall_ex_o       (stall_ex),
        .stall_mem_o      (stall_mem),
        .flush_id_o       (flush_id),
        .flush_ex_o       (flush_ex),
        .hazard_state_o   (hazard_state),
        .mem_timeout_o    (mem_timeout),
        .lu_stall_cnt_o   (lu_stall_cnt),
        .mem_stall_cnt_o  (mem_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: whether a memory wait is in progress, how many
    // wait cycles it has lasted, sticky timeout, and the two event tallies.
    bit m_waiting;
    int m_waited;
    bit m_timeout;
    int m_lu;
    int m_mem;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    function automatic logic [5:0] outs_now();
        return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex};
    endfunction

    task automatic model_reset();
        m_waiting = 0;
        m_waited  = 0;
        m_timeout = 0;
        m_lu      = 0;
        m_mem     = 0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".state"},   32'(hazard_state), 32'(m_waiting));
        check_eq({tag, ".timeout"}, 32'(mem_timeout),  32'(m_timeout));
`ifdef HAZARD_PERF_CNT_EN
        check_eq({tag, ".lu_cnt"},  32'(lu_stall_cnt),  32'(m_lu));
        check_eq({tag, ".mem_cnt"}, 32'(mem_stall_cnt), 32'(m_mem));
`else
        check_eq({tag, ".lu_cnt"},  32'(lu_stall_cnt),  32'd0);
        check_eq({tag, ".mem_cnt"}, 32'(mem_stall_cnt), 32'd0);
`endif
    endtask

    // One pipeline cycle: drive inputs after the falling edge, check the
    // settled outputs, then advance the model as the rising edge will.
    task automatic cycle(input string tag,
                         input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic br,
                         input logic rq, input logic rdy);
        bit mw, lu;
        logic [5:0] exp_outs;
        @(negedge clk);
        rs1_id = r1; rs2_id = r2; rs1_used = u1; rs2_used = u2;
        rd_ex = rd; mem_read_ex = mr; branch_taken_ex = br;
        dmem_req = rq; dmem_ready = rdy;
        #1;
        mw = rq && !rdy;
        lu = mr && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
        // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex}
        if (mw)      exp_outs = 6'b111100;
        else if (br) exp_outs = 6'b000011;
        else if (lu) exp_outs = 6'b110001;
        else         exp_outs = 6'b000000;
        check_eq({tag, ".outs"}, 32'(outs_now()), 32'(exp_outs));
        check_state(tag);
        if (m_waiting) begin
            m_waited++;
            if (m_waited >= TO) m_timeout = 1;
        end
        m_waiting = mw;
        if (!mw) m_waited = 0;
        if (mw && m_mem < 65535) m_mem++;
        if (!mw && !br && lu && m_lu < 65535) m_lu++;
    endtask

    // Reset pulse asserted between clock edges with a memory wait and a branch on the inputs.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        dmem_req = 1; dmem_ready = 0; branch_taken_ex = 1;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_eq({tag, ".rst_outs"}, 32'(outs_now()), 32'd0);
        check_state({tag, ".rst"});
        @(posedge clk);
        #1;
        check_eq({tag, ".rst_hold"}, 32'(outs_now()), 32'd0);
        check_state({tag, ".rst_hold"});
        @(negedge clk);
        rst_n = 1;
        dmem_req = 0; branch_taken_ex = 0;
    endtask

    initial begin
        rst_n = 0;
        rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0;
        rd_ex = 0; mem_read_ex = 0; branch_taken_ex = 0;
        dmem_req = 0; dmem_ready = 0;
        model_reset();
        #1;
        check_eq("reset.outs", 32'(outs_now()), 32'd0);
        check_state("reset");
        @(negedge clk);
        rst_n = 1;

        // Load-use on rs1, then the masked cases.
        cycle("lu_rs1",   5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0);
        cycle("lu_rd0",   5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0);
        cycle("lu_unused",5'd5, 5'd0, 0, 0, 5'd5, 1, 0, 0, 0);
        cycle("lu_rs2",   5'd1, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0);
        // Branch outranks load-use.
        cycle("lu_br",    5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);
        // Freeze with branch held for 3 cycles, then ready releases it.
        for (int i = 0; i < 3; i++) cycle("freeze_br", 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0);
        cycle("ready_br", 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 1);
        cycle("idle",     5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        // Six-cycle wait trips the timeout, which survives the ready.
        for (int i = 0; i < 6; i++) cycle("long_wait", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        cycle("wait_done", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
        cycle("after_to",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        check_eq("timeout_sticky", 32'(mem_timeout), 32'd1);
        // Reset in the middle of a wait.
        cycle("pre_rst",   5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        cycle("pre_rst2",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        pulse_reset("mid_wait");
        cycle("post_rst",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);

        // Randomized traffic with small register ranges so matches are common.
        for (int i = 0; i < 600; i++) begin
            logic [4:0] r1, r2, rd;
            logic u1, u2, mr, br, rq, rdy;
            r1  = 5'($urandom_range(0, 3));
            r2  = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            mr  = 1'($urandom_range(0, 1));
            br  = ($urandom_range(0, 3) == 0);
            rq  = ($urandom_range(0, 2) == 0) || (m_waiting && $urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            cycle("rand", r1, r2, u1, u2, rd, mr, br, rq, rdy);
            if ((i % 200) == 199) pulse_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, sets the MEM_WAIT cycle count at which mem_timeout sets; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 rs1_id, rs2_id  input  5 each  source register addresses of the instruction in IF_ID.
REQ-005 rs1_used, rs2_used  input  1 each  the ID instruction actually reads rs1/rs2.
REQ-006 rd_ex  input  5  destination register of the instruction in ID_EX.
REQ-007 mem_read_ex  input  1  ID_EX instruction is a load.
REQ-008 branch_taken_ex  input  1  taken branch or jump resolved in EX.
REQ-009 dmem_req, dmem_ready  input  1 each  MEM-stage data access request and its completion.
REQ-010 stall_if, stall_id, stall_ex, stall_mem  output  1 each  hold the PC, IF_ID, ID_EX and EX_MEM registers.
REQ-011 flush_id, flush_ex  output  1 each  clear IF_ID and ID_EX to a bubble.
REQ-012 hazard_state  output  2  encoded FSM state: RUN=0, MEM_WAIT=1.
REQ-013 mem_timeout  output  1  sticky flag: a memory wait exceeded TIMEOUT_CYC.
REQ-014 lu_stall_cnt, mem_stall_cnt  output  16 each  performance counters.

Function
REQ-015 Definitions: mem_wait = dmem_req && !dmem_ready; load_use = mem_read_ex && rd_ex!=0 && ((rs1_used && rd_ex==rs1_id) || (rs2_used && rd_ex==rs2_id)).
REQ-016 Stall and flush outputs are combinational from the current inputs; no added latency.
REQ-017 Priority, evaluated every cycle: mem_wait, then branch_taken_ex, then load_use.
REQ-018 mem_wait freezes the pipe: stall_if=stall_id=stall_ex=stall_mem=1, and flush_id=flush_ex=0 regardless of branch or load-use.
REQ-019 With no mem_wait, branch_taken_ex sets flush_id=flush_ex=1 and all stalls to 0; a simultaneous load_use is discarded.
REQ-020 With no mem_wait and no branch, load_use sets stall_if=stall_id=1 and flush_ex=1, with stall_ex=stall_mem=flush_id=0, for exactly that cycle.
REQ-021 With no condition active, all stall and flush outputs are 0.
REQ-022 FSM RUN -> MEM_WAIT on a rising edge where mem_wait=1.
REQ-023 FSM MEM_WAIT -> RUN on the edge where dmem_ready=1 or dmem_req=0.
REQ-024 FSM MEM_WAIT -> MEM_WAIT otherwise.
REQ-025 A 16-bit wait counter clears in RUN and increments each MEM_WAIT cycle, saturating at 0xFFFF.
REQ-026 When the wait counter equals TIMEOUT_CYC-1 while in MEM_WAIT, mem_timeout sets on the next edge and holds until reset; stalls continue unaffected.
REQ-027 A branch held in EX during a freeze takes effect, with flushes, in the first cycle mem_wait is 0.
REQ-028 load_use never asserts on two consecutive non-frozen cycles for the same load, because the bubble clears mem_read_ex.

Reset
REQ-029 On rst_n=0, asynchronously: FSM=RUN, wait counter=0, mem_timeout=0, lu_stall_cnt=0, mem_stall_cnt=0.
REQ-030 During reset, all stall and flush outputs are 0 and hazard_state=0.
REQ-031 Reset asserted mid-MEM_WAIT abandons the wait with no residual state.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN defined: lu_stall_cnt increments in each cycle REQ-020 applies, and mem_stall_cnt increments in each cycle REQ-018 applies; both saturate at 0xFFFF.
REQ-033 HAZARD_PERF_CNT_EN undefined: counters are not built, and both ports remain present and drive constant 0.

Verification
REQ-034 mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used=1 -> that cycle stall_if=stall_id=flush_ex=1; with the macro defined, lu_stall_cnt=1.
REQ-035 Same as REQ-034 but rd_ex=0 or rs1_used=0 -> all outputs 0.
REQ-036 load_use and branch_taken_ex together -> flush_id=flush_ex=1, stall_if=0, lu_stall_cnt unchanged.
REQ-037 dmem_req=1 and dmem_ready=0 for 3 cycles, branch_taken_ex=1 throughout -> all four stalls=1 and flushes=0 for 3 cycles, hazard_state=1; on the ready cycle flush_id=flush_ex=1 and FSM returns to RUN.
REQ-038 TIMEOUT_CYC=4 and dmem_ready held at 0 for 6 cycles -> mem_timeout rises after the 4th MEM_WAIT cycle and stays 1 after ready; pulsing rst_n low clears it.
REQ-039 Reset asserted during MEM_WAIT -> asynchronous return to hazard_state=0 with all outputs 0.
